// File: rtl/darkspi_resp.sv
// darkspi_resp: SPI mode-0 responder, pins oversampled in the CLK domain.
// Deserialises MOSI into RX strobes, serialises a one-entry TX holding register.
module darkspi_resp #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] FILL  = {WIDTH{1'b1}}
) (
    input  logic             CLK,
    input  logic             RES,
    input  logic             SPI_SCK,
    input  logic             SPI_CSN,
    input  logic             SPI_MOSI,
    output logic             SPI_MISO,
    output logic             SPI_MISO_OE,
    input  logic [WIDTH-1:0] TX_DATA,
    input  logic             TX_VALID,
    output logic             TX_READY,
    output logic [WIDTH-1:0] RX_DATA,
    output logic             RX_VALID,
    output logic             UNDERRUN,
    input  logic             UNDERRUN_CLR,
    output logic             BUSY
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t state_q, state_d;

    logic sck_s1, sck_s2, sck_h;
    logic csn_s1, csn_s2, csn_h;
    logic mosi_s1, mosi_s2;
    logic [1:0] fresh;
    logic csn_arm;

    logic [WIDTH-1:0] hold_q;
    logic             hold_full;
    logic [WIDTH-1:0] tx_shift;
    logic [WIDTH-1:0] rx_shift;
    logic [CW-1:0]    bitcnt;
    logic             load_armed;
    logic [WIDTH-1:0] rx_data_q;
    logic             rx_valid_q;
    logic             underrun_q;

    logic sck_rise, sck_fall, csn_fall, csn_rise;
    logic word_done, do_load, go_idle, wr_accept;

    always_ff @(posedge CLK) begin
        if (RES) begin
            sck_s1  <= 1'b0;
            sck_s2  <= 1'b0;
            sck_h   <= 1'b0;
            csn_s1  <= 1'b1;
            csn_s2  <= 1'b1;
            csn_h   <= 1'b1;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
            fresh   <= 2'b00;
            csn_arm <= 1'b0;
        end else begin
            sck_s1  <= SPI_SCK;
            sck_s2  <= sck_s1;
            sck_h   <= sck_s2;
            csn_s1  <= SPI_CSN;
            csn_s2  <= csn_s1;
            csn_h   <= csn_s2;
            mosi_s1 <= SPI_MOSI;
            mosi_s2 <= mosi_s1;
            fresh   <= {fresh[0], 1'b1};
            // A CSN held low across reset must be seen high from the pin first.
            if (fresh[1] && csn_s2)
                csn_arm <= 1'b1;
        end
    end

    assign sck_rise  = sck_s2 & ~sck_h;
    assign sck_fall  = ~sck_s2 & sck_h;
    assign csn_fall  = csn_arm & csn_h & ~csn_s2;
    assign csn_rise  = ~csn_h & csn_s2;
    assign word_done = sck_rise && (bitcnt == CW'(WIDTH - 1));
    assign wr_accept = TX_VALID & ~hold_full;

    always_ff @(posedge CLK) begin
        if (RES)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        do_load = 1'b0;
        go_idle = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (csn_fall) begin
                    state_d = ACTIVE;
                    do_load = 1'b1;
                end
            end
            ACTIVE: begin
                if (csn_rise) begin
                    state_d = IDLE;
                    go_idle = 1'b1;
                end else if (sck_fall && load_armed) begin
                    do_load = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            tx_shift   <= {WIDTH{1'b1}};
            rx_shift   <= '0;
            bitcnt     <= '0;
            load_armed <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (go_idle) begin
                tx_shift   <= {WIDTH{1'b1}};
                rx_shift   <= '0;
                bitcnt     <= '0;
                load_armed <= 1'b0;
            end else if (do_load) begin
                tx_shift   <= hold_full ? hold_q : FILL;
                bitcnt     <= '0;
                load_armed <= 1'b0;
            end else if (state_q == ACTIVE && sck_rise) begin
                rx_shift <= {rx_shift[WIDTH-2:0], mosi_s2};
                if (word_done) begin
                    rx_data_q  <= {rx_shift[WIDTH-2:0], mosi_s2};
                    rx_valid_q <= 1'b1;
                    bitcnt     <= '0;
                    load_armed <= 1'b1;
                end else begin
                    bitcnt <= bitcnt + CW'(1);
                end
            end else if (state_q == ACTIVE && sck_fall) begin
                tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
            end
        end
    end

    // A load from an empty register leaves a same-cycle write in place.
    always_ff @(posedge CLK) begin
        if (RES) begin
            hold_q     <= '0;
            hold_full  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            if (do_load && hold_full) begin
                hold_full <= 1'b0;
            end else if (wr_accept) begin
                hold_full <= 1'b1;
                hold_q    <= TX_DATA;
            end
            if (do_load && !hold_full)
                underrun_q <= 1'b1;
            else if (UNDERRUN_CLR)
                underrun_q <= 1'b0;
        end
    end

    assign SPI_MISO    = tx_shift[WIDTH-1];
    assign SPI_MISO_OE = ~csn_s2;
    assign TX_READY    = ~hold_full;
    assign RX_DATA     = rx_data_q;
    assign RX_VALID    = rx_valid_q;
    assign UNDERRUN    = underrun_q;
    assign BUSY        = (state_q == ACTIVE);

endmodule

// File: tb/tb_darkspi_resp.sv
// tb_darkspi_resp: directed and random SPI transfers against a
// word-level model of the holding register, FILL loads and received words.
module tb_darkspi_resp;

    localparam logic [7:0] FILL_V = 8'hFF;

    logic       clk = 1'b0;
    logic       res;
    logic       sck, csn, mosi;
    logic       miso, miso_oe;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       underrun, underrun_clr;
    logic       busy;

    darkspi_resp #(.WIDTH(8), .FILL(FILL_V)) dut (
        .CLK(clk), .RES(res),
        .SPI_SCK(sck), .SPI_CSN(csn), .SPI_MOSI(mosi),
        .SPI_MISO(miso), .SPI_MISO_OE(miso_oe),
        .TX_DATA(tx_data), .TX_VALID(tx_valid), .TX_READY(tx_ready),
        .RX_DATA(rx_data), .RX_VALID(rx_valid),
        .UNDERRUN(underrun), .UNDERRUN_CLR(underrun_clr),
        .BUSY(busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] rx_q[$];
    logic [7:0] exp_rx[$];
    logic [7:0] hold_m[$];
    logic       underrun_m = 1'b0;
    logic [7:0] cur_tx;
    logic [7:0] last_rx = 8'h00;

    always @(negedge clk)
        if (rx_valid === 1'b1)
            rx_q.push_back(rx_data);

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] load_word();
        if (hold_m.size() != 0)
            return hold_m.pop_front();
        underrun_m = 1'b1;
        return FILL_V;
    endfunction

    task automatic tx_write(input logic [7:0] d);
        int k = 0;
        @(negedge clk);
        while (tx_ready !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("tx_ready_wait", tx_ready, 1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        hold_m.push_back(d);
        check("tx_ready_full", tx_ready, 0);
    endtask

    task automatic spi_bits(input int n, input logic [7:0] m,
                            output logic [7:0] got);
        got = 8'h00;
        for (int i = 0; i < n; i++) begin
            mosi = m[7-i];
            repeat (4) @(negedge clk);
            got = {got[6:0], miso};
            sck = 1'b1;
            repeat (4) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    task automatic csn_low();
        csn = 1'b0;
        repeat (6) @(negedge clk);
        cur_tx = load_word();
    endtask

    task automatic csn_high();
        repeat (3) @(negedge clk);
        csn = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic word(input logic [7:0] m, input string tag);
        logic [7:0] got;
        spi_bits(8, m, got);
        check({tag, "_miso"}, got, cur_tx);
        exp_rx.push_back(m);
        cur_tx = load_word();
        // Let the end-of-word load land before any following write.
        repeat (3) @(negedge clk);
    endtask

    task automatic check_rx(input string tag);
        check({tag, "_rx_count"}, rx_q.size(), exp_rx.size());
        while (exp_rx.size() != 0 && rx_q.size() != 0) begin
            last_rx = exp_rx.pop_front();
            check({tag, "_rx_data"}, rx_q.pop_front(), last_rx);
        end
        exp_rx.delete();
        rx_q.delete();
        check({tag, "_rx_hold"}, rx_data, last_rx);
    endtask

    task automatic check_clear_underrun(input string tag);
        check({tag, "_underrun"}, underrun, underrun_m);
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        underrun_m   = 1'b0;
        @(negedge clk);
        check({tag, "_underrun_clr"}, underrun, 0);
    endtask

    initial begin
        logic [7:0] dummy;
        logic       seen;
        int         nw;

        res = 1'b1; csn = 1'b1; sck = 1'b0; mosi = 1'b0;
        tx_data = 8'h00; tx_valid = 1'b0; underrun_clr = 1'b0;
        repeat (4) @(negedge clk);
        res = 1'b0;
        repeat (4) @(negedge clk);

        check("rst_miso", miso, 1);
        check("rst_oe", miso_oe, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_underrun", underrun, 0);
        check("rst_busy", busy, 0);

        spi_bits(8, 8'hA5, dummy);
        repeat (6) @(negedge clk);
        check("idle_sck_rx", rx_q.size(), 0);
        check("idle_sck_busy", busy, 0);
        check("idle_sck_oe", miso_oe, 0);

        tx_write(8'hA5);
        csn_low();
        check("single_busy", busy, 1);
        check("single_oe", miso_oe, 1);
        check("single_tx_ready", tx_ready, 1);
        word(8'h3C, "single");
        csn_high();
        check_rx("single");
        check("single_idle", busy, 0);
        check_clear_underrun("single");

        tx_write(8'h12);
        csn_low();
        tx_write(8'h34);
        word(8'hF0, "b2b0");
        word(8'h0F, "b2b1");
        csn_high();
        check_rx("b2b");
        check_clear_underrun("b2b");

        csn_low();
        word(8'($urandom), "under");
        csn_high();
        check_rx("under");
        check_clear_underrun("under");

        underrun_clr = 1'b1;
        csn  = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen |= underrun;
        end
        underrun_clr = 1'b0;
        cur_tx = load_word();
        underrun_m = 1'b0;
        check("set_wins_seen", seen, 1);
        check("set_wins_cleared", underrun, 0);
        word(8'($urandom), "setwin");
        csn_high();
        check_rx("setwin");
        check_clear_underrun("setwin");

        csn_low();
        spi_bits(5, 8'hA7, dummy);
        csn_high();
        check("abort_rx_count", rx_q.size(), 0);
        check("abort_rx_data", rx_data, last_rx);
        csn_low();
        word(8'h81, "after_abort");
        csn_high();
        check_rx("after_abort");
        check_clear_underrun("after_abort");

        tx_write(8'h66);
        csn_low();
        spi_bits(3, 8'hC3, dummy);
        res = 1'b1;
        repeat (2) @(negedge clk);
        res = 1'b0;
        hold_m.delete();
        underrun_m = 1'b0;
        last_rx    = 8'h00;
        repeat (4) @(negedge clk);
        check("rstmid_busy", busy, 0);
        check("rstmid_miso", miso, 1);
        check("rstmid_rx_data", rx_data, 0);
        check("rstmid_underrun", underrun, 0);
        check("rstmid_tx_ready", tx_ready, 1);
        spi_bits(8, 8'h99, dummy);
        repeat (8) @(negedge clk);
        check("rstmid_ignore_rx", rx_q.size(), 0);
        check("rstmid_ignore_busy", busy, 0);
        csn = 1'b1;
        repeat (8) @(negedge clk);
        csn_low();
        word(8'h55, "rstmid_55");
        csn_high();
        check_rx("rstmid_55");
        check_clear_underrun("rstmid_55");

        for (int it = 0; it < 8; it++) begin
            nw = $urandom_range(1, 3);
            if ($urandom_range(0, 1) == 1)
                tx_write(8'($urandom));
            csn_low();
            for (int w = 0; w < nw; w++) begin
                if ($urandom_range(0, 1) == 1 && hold_m.size() == 0)
                    tx_write(8'($urandom));
                word(8'($urandom), "rand");
            end
            csn_high();
            check_rx("rand");
            check_clear_underrun("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
